// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: bus opcodes and bus T-states
package cpu_pkg;

  // Encodings 4..7 are unused and are executed as IDLE by bus_unit.
  typedef enum logic [2:0] {
    BUS_IDLE  = 3'd0,
    BUS_IF    = 3'd1,
    BUS_READ  = 3'd2,
    BUS_WRITE = 3'd3
  } bus_opcode_t;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2,
    T4 = 2'd3
  } t_state_t;

endpackage

// File: rtl/bus_unit.sv
// rtl/bus_unit.sv - memory-bus sequencer: runs one bus opcode per M-cycle over T1..T4
module bus_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] RESET_OPCODE = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  bus_opcode_t       bus_opcode,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              data_in_reg_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] next_opcode,
  output logic [DATA_W-1:0] tmp_data,
  output logic [1:0]        t_state,
  output logic              mcycle_done
);

  t_state_t          state_q, state_d;
  bus_opcode_t       op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              dwr_q, dwr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] tmp_q, tmp_d;
  logic              strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= T1;
      op_q    <= BUS_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      dwr_q   <= 1'b0;
      ir_q    <= RESET_OPCODE;
      tmp_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dwr_q   <= dwr_d;
      ir_q    <= ir_d;
      tmp_q   <= tmp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dwr_d   = dwr_q;
    ir_d    = ir_q;
    tmp_d   = tmp_q;
    case (state_q)
      T1: begin
        // Normalise the opcode at capture so later stages only see legal ops.
        case (bus_opcode)
          BUS_IF, BUS_READ, BUS_WRITE: op_d = bus_opcode;
          default:                     op_d = BUS_IDLE;
        endcase
        addr_d  = addr_in;
        wdata_d = wdata_in;
        dwr_d   = data_in_reg_wr;
        state_d = T2;
      end
      T2: state_d = T3;
      T3: begin
        if (op_q == BUS_IDLE) begin
          state_d = T4;
        end else if (mem_ready) begin
          state_d = T4;
          if (op_q == BUS_IF) ir_d = mem_rdata;
          if (op_q == BUS_READ && dwr_q) tmp_d = mem_rdata;
        end
      end
      T4: state_d = T1;
    endcase
  end

  assign strobe      = (state_q == T2) || (state_q == T3);
  assign mem_rd      = strobe && ((op_q == BUS_IF) || (op_q == BUS_READ));
  assign mem_wr      = strobe && (op_q == BUS_WRITE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign next_opcode = ir_q;
  assign tmp_data    = tmp_q;
  assign t_state     = state_q;
  assign mcycle_done = (state_q == T4);

endmodule

// File: tb/tb_bus_unit.sv
// tb/tb_bus_unit.sv - self-checking bench for bus_unit
module tb_bus_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  bus_opcode_t bus_opcode;
  logic [15:0] addr_in;
  logic [7:0]  wdata_in;
  logic        data_in_reg_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [7:0]  next_opcode;
  logic [7:0]  tmp_data;
  logic [1:0]  t_state;
  logic        mcycle_done;

  bus_unit #(.ADDR_W(16), .DATA_W(8), .RESET_OPCODE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .bus_opcode(bus_opcode), .addr_in(addr_in),
    .wdata_in(wdata_in), .data_in_reg_wr(data_in_reg_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .next_opcode(next_opcode), .tmp_data(tmp_data),
    .t_state(t_state), .mcycle_done(mcycle_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: what the bus unit should be presenting, by the rules.
  logic [15:0] addr_m;
  logic [7:0]  wdata_m;
  logic [7:0]  ir_m;
  logic [7:0]  tmp_m;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        dwr;
    logic [7:0]  rdata;
    int          waits;
    logic [7:0]  exp_ir;
    logic [7:0]  exp_tmp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input int ts, input logic rd, input logic wr,
                             input logic done);
    string p;
    p = $sformatf("%s T%0d", tag, ts + 1);
    chk({p, " t_state"}, 32'(t_state), 32'(ts));
    chk({p, " mem_rd"}, 32'(mem_rd), 32'(rd));
    chk({p, " mem_wr"}, 32'(mem_wr), 32'(wr));
    chk({p, " mcycle_done"}, 32'(mcycle_done), 32'(done));
    chk({p, " mem_addr"}, 32'(mem_addr), 32'(addr_m));
    chk({p, " mem_wdata"}, 32'(mem_wdata), 32'(wdata_m));
    chk({p, " next_opcode"}, 32'(next_opcode), 32'(ir_m));
    chk({p, " tmp_data"}, 32'(tmp_data), 32'(tmp_m));
  endtask

  // Called just after an active edge with the DUT in T1; returns just after the edge leaving T4.
  task automatic run_mcycle(input string tag, input logic [2:0] op, input logic [15:0] addr,
                            input logic [7:0] wd, input logic dwr, input logic [7:0] rd,
                            input int waits);
    logic [2:0] eop;
    logic       is_rd, is_wr;
    int         n3;
    eop   = (op >= 3'd1 && op <= 3'd3) ? op : 3'd0;
    is_rd = (eop == 3'd1) || (eop == 3'd2);
    is_wr = (eop == 3'd3);
    n3    = (eop == 3'd0) ? 1 : waits + 1;

    bus_opcode     = bus_opcode_t'(op);
    addr_in        = addr;
    wdata_in       = wd;
    data_in_reg_wr = dwr;
    mem_ready      = (eop == 3'd0) ? 1'b0 : 1'($urandom);
    mem_rdata      = 8'($urandom);
    @(negedge clk);
    check_cycle(tag, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    addr_m  = addr;
    wdata_m = wd;

    // Inputs move after T1; the captured transaction must not.
    bus_opcode     = (op == 3'd2) ? BUS_WRITE : BUS_READ;
    addr_in        = 16'($urandom);
    wdata_in       = 8'($urandom);
    data_in_reg_wr = ~dwr;
    mem_ready      = (eop == 3'd0) ? 1'b0 : 1'($urandom);
    mem_rdata      = 8'($urandom);
    @(negedge clk);
    check_cycle(tag, 1, is_rd, is_wr, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < n3; i++) begin
      mem_ready = (eop == 3'd0) ? 1'b0 : (i == n3 - 1);
      mem_rdata = (i == n3 - 1) ? rd : 8'($urandom);
      @(negedge clk);
      check_cycle(tag, 2, is_rd, is_wr, 1'b0);
      @(posedge clk); #1;
    end
    if (eop == 3'd1) ir_m = rd;
    if (eop == 3'd2 && dwr) tmp_m = rd;

    mem_ready = (eop == 3'd0) ? 1'b0 : 1'($urandom);
    mem_rdata = 8'($urandom);
    @(negedge clk);
    check_cycle(tag, 3, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{3'd1, 16'h0100, 8'h00, 1'b0, 8'h3C, 0, 8'h3C, 8'h00};
    vecs[1] = '{3'd2, 16'hC000, 8'h00, 1'b1, 8'h5A, 3, 8'h3C, 8'h5A};
    vecs[2] = '{3'd3, 16'hFFFF, 8'hA5, 1'b1, 8'h77, 1, 8'h3C, 8'h5A};
    vecs[3] = '{3'd0, 16'h1234, 8'h66, 1'b1, 8'h99, 0, 8'h3C, 8'h5A};
    vecs[4] = '{3'd2, 16'h2000, 8'h00, 1'b0, 8'h11, 0, 8'h3C, 8'h5A};
    vecs[5] = '{3'd5, 16'h4444, 8'h00, 1'b1, 8'h22, 2, 8'h3C, 8'h5A};
    vecs[6] = '{3'd1, 16'h0001, 8'h00, 1'b0, 8'hC9, 2, 8'hC9, 8'h5A};

    rst_n          = 1'b0;
    bus_opcode     = BUS_IDLE;
    addr_in        = 16'h0;
    wdata_in       = 8'h0;
    data_in_reg_wr = 1'b0;
    mem_rdata      = 8'h0;
    mem_ready      = 1'b0;
    addr_m = 16'h0; wdata_m = 8'h0; ir_m = 8'h00; tmp_m = 8'h00;
    #3;
    check_cycle("reset", 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_mcycle($sformatf("vec%0d", v), vecs[v].op, vecs[v].addr, vecs[v].wdata,
                 vecs[v].dwr, vecs[v].rdata, vecs[v].waits);
      chk($sformatf("vec%0d ir", v), 32'(next_opcode), 32'(vecs[v].exp_ir));
      chk($sformatf("vec%0d tmp", v), 32'(tmp_data), 32'(vecs[v].exp_tmp));
    end

    for (int r = 0; r < 40; r++) begin
      run_mcycle($sformatf("rnd%0d", r), 3'($urandom_range(0, 7)), 16'($urandom),
                 8'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 3));
    end

    // Reset dropped while a READ waits in T3.
    bus_opcode = BUS_READ; addr_in = 16'hC000; wdata_in = 8'h00; data_in_reg_wr = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait mem_rd", 32'(mem_rd), 32'd1);
    chk("wait t_state", 32'(t_state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    addr_m = 16'h0; wdata_m = 8'h0; ir_m = 8'h00; tmp_m = 8'h00;
    check_cycle("async reset", 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_mcycle("after reset", 3'd1, 16'h0300, 8'h00, 1'b0, 8'h7E, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_unit.md
# bus_unit

Memory-bus sequencer that sits directly downstream of `control`. Each M-cycle it executes the `bus_opcode_t` that `control` issues (IDLE, IF, READ, WRITE) against the external memory port, split into four T-states. It latches fetched opcodes into the instruction register that drives `control.next_opcode`, and latches read data into the TMP (data-in) register. It also produces the M-cycle-done strobe that qualifies `control`'s M-cycle advance, stretching the M-cycle while memory inserts wait states.

## Interface
Parameters:
- `ADDR_W`, 16, address width
- `DATA_W`, 8, data width
- `RESET_OPCODE`, 8'h00, IR value after reset (NOP)

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `bus_opcode`  in  `bus_opcode_t`  operation for this M-cycle, from `control`
- `addr_in`  in  ADDR_W  address from register-file 16-bit read port
- `wdata_in`  in  DATA_W  write data from the `data_out_ctrl` mux
- `data_in_reg_wr`  in  1  load TMP on READ completion
- `mem_addr`  out  ADDR_W  external address
- `mem_wdata`  out  DATA_W  external write data
- `mem_rd`  out  1  read strobe
- `mem_wr`  out  1  write strobe
- `mem_rdata`  in  DATA_W  external read data
- `mem_ready`  in  1  memory completion; sampled only in T3
- `next_opcode`  out  DATA_W  instruction register
- `tmp_data`  out  DATA_W  TMP register (ALU_SRC_*_TMP source)
- `t_state`  out  2  current T-state, 0..3 = T1..T4
- `mcycle_done`  out  1  one-clk pulse in T4; `control` advances its M-cycle only when this is high

## Operation
- FSM states T1 → T2 → T3 → (T3 while waiting) → T4 → T1.
- T1: capture `bus_opcode`, `addr_in` and `wdata_in` into internal regs. Later changes to these inputs within the M-cycle are ignored.
  - Unknown encodings are treated as IDLE.
- `mem_addr` and `mem_wdata` come from the captured regs, valid from the clk after the T1 edge through T4.
- IF/READ: `mem_rd`=1 in T2 and T3.
- WRITE: `mem_wr`=1 in T2 and T3.
- IDLE: no strobes. `mem_ready` is ignored and there are no waits.
- T3 with non-IDLE op:
  - `mem_ready`=0: stay in T3 (wait state) with strobes held.
  - `mem_ready`=1: go to T4.
  - On that edge, IF loads `next_opcode` ← `mem_rdata`.
  - READ with captured `data_in_reg_wr`=1 loads `tmp_data` ← `mem_rdata`.
  - WRITE loads nothing.
- T4: strobes low, `mcycle_done`=1, next state T1.
- `next_opcode` and `tmp_data` hold their value until the next qualifying load.

## Timing
- Reset values: `t_state`=0 (T1), `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `next_opcode`=RESET_OPCODE, `tmp_data`=0, `mcycle_done`=0.
- Zero-wait M-cycle = 4 clk. Each clk of `mem_ready`=0 in T3 adds 1 clk. There is no timeout.
- Read data is visible on `next_opcode`/`tmp_data` from the T4 clk onward. It is therefore valid when `control` samples it in the following M-cycle's T1.
- `mcycle_done` is high for exactly one clk per M-cycle, never during waits.
- Reset asserted mid-M-cycle: all outputs take reset values immediately (asynchronously). After release, the first active edge is T1 with a fresh capture; no partial transaction is completed.
- `mem_ready` high outside T3 has no effect.
- Address arithmetic is pass-through. 16'hFFFF is used as-is; no wrap logic lives here.

## Structure
- Package `cpu_pkg`:
  - add `t_state_t` (T1, T2, T3, T4);
  - reuse the existing `bus_opcode_t`.
- Single module, no sub-module. The FSM, capture regs, IR and TMP are all local.

## Test plan
- Reset release, `bus_opcode`=IF, addr 16'h0100, `mem_rdata`=8'h3C, `mem_ready`=1 → `mem_rd` high 2 clk, `next_opcode`=8'h3C at T4, `mcycle_done` pulse 4 clk after release.
- READ 16'hC000 with `data_in_reg_wr`=1, `mem_ready` low 3 clk → 7-clk M-cycle, `tmp_data`=`mem_rdata`, `next_opcode` unchanged.
- WRITE 16'hFFFF, `wdata_in`=8'hA5 → `mem_wr` high in T2–T3, `mem_addr`=16'hFFFF, `mem_wdata`=8'hA5, no register load.
- IDLE with `mem_ready`=0 held → no strobes, M-cycle still 4 clk.
- Change `bus_opcode` from READ to WRITE in T2 → transaction stays READ.
- Drop `rst_n` in T3 while waiting → strobes low within the same clk, `next_opcode`=8'h00, restart in T1.
